// File: rtl/bit_count_ud_add_g.sv
// rtl/bit_count_ud_add_g.sv - two-bit up/down counter with combinational terminal-count flag
module bit_count_ud_add_g (
   output logic [1:0] q,
   output logic       l,
   input  logic       x,
   input  logic       clk,
   input  logic       reset
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= 2'b00;
      end else if (x) begin
         q <= q - 2'd1;
      end else begin
         q <= q + 2'd1;
      end
   end

   // G block: high when the next edge wraps in the currently selected direction
   assign l = (!x && (q == 2'd3)) || (x && (q == 2'd0));

endmodule

// File: tb/tb_bit_count_ud_add_g.sv
// tb/tb_bit_count_ud_add_g.sv - directed table-driven bench for bit_count_ud_add_g
module tb_bit_count_ud_add_g;

   logic       clk;
   logic       reset;
   logic       x;
   logic [1:0] q;
   logic       l;

   int total;
   int passed;

   typedef struct {
      logic       rst_before;
      logic       dir;
      logic [1:0] exp_q;
      logic       exp_l;
   } vec_t;

   vec_t vecs[13];

   bit_count_ud_add_g dut (
      .q     (q),
      .l     (l),
      .x     (x),
      .clk   (clk),
      .reset (reset)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [1:0] eq, input logic el);
      total++;
      if (q === eq && l === el) begin
         passed++;
      end else begin
         $display("FAIL %s: got q=%0d l=%0b, expected q=%0d l=%0b", nm, q, l, eq, el);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      reset = 1'b1;
   endtask

   initial begin
      total  = 0;
      passed = 0;

      // up 8 edges after reset
      vecs[0]  = '{1'b1, 1'b0, 2'd1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 2'd2, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 2'd3, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 2'd1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 2'd2, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 2'd3, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 2'd0, 1'b0};
      // down 5 edges after reset
      vecs[8]  = '{1'b1, 1'b1, 2'd3, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 2'd2, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 2'd1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 2'd0, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 2'd3, 1'b0};

      // reset held with clock running
      reset = 1'b0;
      x     = 1'b0;
      #2;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("reset_hold_%0d", i), 2'd0, 1'b0);
         #5;
      end
      // now at t=27 (between edges 25 and 35)
      x = 1'b1;
      #1;
      check("reset_x1", 2'd0, 1'b1);

      for (int i = 0; i < 13; i++) begin
         x = vecs[i].dir;
         if (vecs[i].rst_before) pulse_reset();
         @(posedge clk);
         #1;
         check($sformatf("vec_%0d", i), vecs[i].exp_q, vecs[i].exp_l);
      end

      // direction reversal at q=2
      x = 1'b0;
      pulse_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rev_q2", 2'd2, 1'b0);
      x = 1'b1;
      #1;
      check("rev_x1_comb", 2'd2, 1'b0);
      @(posedge clk); #1;
      check("rev_q1", 2'd1, 1'b0);
      @(posedge clk); #1;
      check("rev_q0", 2'd0, 1'b1);

      // async reset mid-count
      x = 1'b0;
      pulse_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("async_pre", 2'd2, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("async_clear", 2'd0, 1'b0);
      @(posedge clk); #1;
      check("async_hold_1", 2'd0, 1'b0);
      @(posedge clk); #1;
      check("async_hold_2", 2'd0, 1'b0);
      x     = 1'b1;
      reset = 1'b1;
      #1;
      check("async_release", 2'd0, 1'b1);
      @(posedge clk); #1;
      check("async_first_edge", 2'd3, 1'b0);

      // exhaustive l over q and x
      for (int v = 0; v < 4; v++) begin
         logic [1:0] tq;
         tq = 2'(v);
         x = 1'b0;
         pulse_reset();
         for (int k = 0; k < v; k++) begin
            @(posedge clk); #1;
         end
         x = 1'b0;
         #1;
         check($sformatf("lmap_q%0d_x0", v), tq, (v == 3) ? 1'b1 : 1'b0);
         x = 1'b1;
         #1;
         check($sformatf("lmap_q%0d_x1", v), tq, (v == 0) ? 1'b1 : 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
